baud_rate_ctrl: RTL and testbench
=================================

# baud_rate_ctrl

Runtime-configurable baud tick controller for the UART in the ping-pong game link. It sequences the oversampling tick divider and accepts new divisor values from the host-side config logic through a valid/ready handshake. Updates are applied only on tick boundaries so a frame in progress never sees a shortened period. It drives the 16x sample tick to the UART receiver and the derived 1x bit tick to the transmitter.

## Interface
- DVSR_W, 16, divisor width in bits
- DEFAULT_DVSR, 326, divisor loaded at reset (100 MHz clk, 19200 baud, 16x oversample)
- OVS, 16, s_tick pulses per bit_tick
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clk
- en  in  1  run enable; low holds dividers cleared
- cfg_valid  in  1  new divisor offered
- cfg_dvsr  in  DVSR_W  offered divisor, clk cycles per s_tick
- cfg_ready  out  1  controller can accept a divisor
- cfg_err  out  1  one-cycle pulse when an offered divisor is rejected
- s_tick  out  1  one-cycle oversample tick
- bit_tick  out  1  one-cycle bit tick, coincident with every OVS-th s_tick
- dvsr_q  out  DVSR_W  divisor currently in effect

## Operation
- States: IDLE (en=0), RUN (en=1, no pending update), PEND (en=1, accepted divisor waiting for boundary).
- Divider counter cnt counts 0..dvsr_q-1, then wraps to 0. s_tick is registered and high on the cycle after cnt = dvsr_q-1.
- Oversample counter ocnt advances on each s_tick, 0..OVS-1. bit_tick asserts with the s_tick at which ocnt wraps from OVS-1.
- Handshake: transfer occurs when cfg_valid & cfg_ready. cfg_ready = 1 in IDLE and RUN, 0 in PEND.
- cfg_dvsr < 2 is rejected: the transfer still completes, cfg_err pulses the next cycle, and dvsr_q and the state are unchanged.
- Valid transfer in IDLE: dvsr_q loads the next cycle and the state stays IDLE.
- Valid transfer in RUN: the value is held in a pending register and the state moves to PEND.
- In PEND, on the cycle cnt wraps: dvsr_q loads from pending and the state returns to RUN. The period that just finished uses the old divisor.
- A transfer in RUN on the same cycle as a wrap still goes to PEND. It applies at the following wrap.
- en falling in any state: cnt and ocnt clear and the state goes to IDLE. In PEND, the pending value is applied immediately on that transition.
- en rising: IDLE to RUN with cnt = 0. The first s_tick comes exactly dvsr_q cycles after en is first sampled high.

## Timing
- Reset values: cfg_ready=1, cfg_err=0, s_tick=0, bit_tick=0, dvsr_q=DEFAULT_DVSR, cnt=0, ocnt=0, state IDLE.
- Asserting reset_n low mid-operation discards any pending divisor immediately.
- s_tick period in steady RUN is exactly dvsr_q cycles. bit_tick period is OVS*dvsr_q cycles.
- cfg_err latency is 1 cycle after the transfer. dvsr_q update latency is 1 cycle in IDLE and at most dvsr_q cycles in RUN.
- cnt compares against dvsr_q-1 in DVSR_W bits. Since dvsr_q ≥ 2 always holds, the subtraction never underflows.

## Configuration
- BAUD_FRAC_EN defined:
  - Adds input cfg_frac [3:0], latched with cfg_dvsr on transfer.
  - A 4-bit phase accumulator adds cfg_frac at each s_tick. Each carry-out stretches the next s_tick period to dvsr_q+1.
  - Result: cfg_frac of every 16 periods are dvsr_q+1 cycles long.
  - The accumulator clears with en low and on reset.
- BAUD_FRAC_EN undefined: the cfg_frac port is absent and every period is exactly dvsr_q cycles.

## Structure
- Shared package baud_pkg holds:
  - state enum {IDLE, RUN, PEND}
  - MIN_DVSR = 2
  - default OVS and DEFAULT_DVSR constants
- One sub-module, baud_frac_acc: the fractional phase accumulator emitting a stretch flag. It is instantiated only under BAUD_FRAC_EN.

## Test plan
- Reset, then en=1 with the default divisor: first s_tick at cycle 326, next at 652; bit_tick first at cycle 5216.
- In IDLE, write cfg_dvsr=10 and raise en: s_tick every 10 cycles, bit_tick every 160; dvsr_q=10 one cycle after the transfer.
- In RUN with dvsr 10, write 4 at cnt=3: cfg_ready=0 until the wrap; the current period ends at 10 cycles, then periods are 4; cfg_ready returns to 1.
- Write cfg_dvsr=1, then 0: cfg_err pulses once for each, dvsr_q is unchanged, and tick spacing is unaffected.
- In PEND, drop en: ticks stop the next cycle and dvsr_q takes the pending value. Re-raise en: first s_tick after the new divisor count.
- BAUD_FRAC_EN with dvsr=10, frac=4: every 16 consecutive s_tick periods sum to 164 cycles; assert reset_n low mid-run and check all outputs return to reset values.

Source files
------------

// File: rtl/baud_pkg.sv
// Purpose : shared types and constants for the UART baud tick controller.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package baud_pkg;

    // IDLE: dividers held cleared; RUN: ticking; PEND: accepted divisor waits for wrap
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // Smallest divisor that still yields a one-cycle-low gap between s_ticks
    localparam int MIN_DVSR = 2;

    // 100 MHz clk, 19200 baud, 16x oversample
    localparam int DEF_OVS  = 16;
    localparam int DEF_DVSR = 326;

endpackage

// File: rtl/baud_frac_acc.sv
// Purpose : 4-bit fractional phase accumulator; a carry-out stretches the next s_tick period by one clk.
// Latency : stretch updates the cycle after each adv pulse.
// Backpressure: none; adv is a free-running tick, clr has priority.
//
// Ports:
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous clear (controller not running)
//   adv          : add frac to the accumulator (one per s_tick)
//   frac         : fractional increment, sixteenths of a clk
//   stretch      : high while the current period must be one clk longer
module baud_frac_acc (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       adv,
    input  logic [3:0] frac,
    output logic       stretch
);

    logic [3:0] acc_q;
    logic [3:0] acc_d;
    logic       stretch_q;
    logic       stretch_d;
    logic [4:0] sum;

    always_comb begin
        sum       = {1'b0, acc_q} + {1'b0, frac};
        acc_d     = acc_q;
        stretch_d = stretch_q;
        if (clr) begin
            acc_d     = 4'd0;
            stretch_d = 1'b0;
        end else if (adv) begin
            acc_d     = sum[3:0];
            // carry decides the length of the period that starts now
            stretch_d = sum[4];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= 4'd0;
            stretch_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            stretch_q <= stretch_d;
        end
    end

    assign stretch = stretch_q;

endmodule

// File: rtl/baud_rate_ctrl.sv
// Purpose : UART baud tick generator (16x s_tick, 1x bit_tick) with divisor updates on tick boundaries.
// Latency : first s_tick dvsr_q cycles after en sampled high; cfg_err 1 cycle; dvsr_q update 1 cycle (IDLE) / <= dvsr_q (RUN).
// Backpressure: cfg_ready low while an accepted divisor is pending; divisors < 2 complete but are dropped with cfg_err.
//
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   en                  : run enable, low holds dividers cleared
//   cfg_valid/cfg_ready : divisor handshake, cfg_dvsr = clk cycles per s_tick
//   cfg_frac            : fractional sixteenths (only with BAUD_FRAC_EN defined)
//   cfg_err             : one-cycle pulse for a rejected divisor
//   s_tick, bit_tick    : one-cycle tick outputs
//   dvsr_q              : divisor currently in effect
// Optional feature macro: BAUD_FRAC_EN (fractional divisor via baud_frac_acc).
module baud_rate_ctrl
    import baud_pkg::*;
#(
    parameter int DVSR_W       = 16,
    parameter int DEFAULT_DVSR = DEF_DVSR,
    parameter int OVS          = DEF_OVS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              cfg_valid,
    input  logic [DVSR_W-1:0] cfg_dvsr,
`ifdef BAUD_FRAC_EN
    input  logic [3:0]        cfg_frac,
`endif
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic              s_tick,
    output logic              bit_tick,
    output logic [DVSR_W-1:0] dvsr_q
);

    localparam int                OCNT_W   = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [DVSR_W-1:0] DVSR_RST = DVSR_W'(DEFAULT_DVSR);
    localparam logic [DVSR_W-1:0] DVSR_MIN = DVSR_W'(MIN_DVSR);
    localparam logic [DVSR_W-1:0] DVSR_ONE = DVSR_W'(1);
    localparam logic [OCNT_W-1:0] OCNT_MAX = OCNT_W'(OVS - 1);
    localparam logic [OCNT_W-1:0] OCNT_ONE = OCNT_W'(1);

    state_t            state_q, state_d;
    logic [DVSR_W-1:0] cnt_q, cnt_d;
    logic [DVSR_W-1:0] dvsr_d;
    logic [DVSR_W-1:0] pend_q, pend_d;
    logic [OCNT_W-1:0] ocnt_q, ocnt_d;
    logic              s_tick_q, s_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              cfg_err_q, cfg_err_d;

    logic              running;
    logic              wrap;
    logic              xfer;
    logic              dvsr_ok;
    logic              stretch;
    logic [DVSR_W-1:0] cnt_lim;
    logic              load_now;    // offered divisor takes effect next cycle
    logic              load_pend;   // offered divisor parked until the next wrap
    logic              apply_pend;  // parked divisor takes effect next cycle

    // Dividers only count once the FSM has left IDLE; the IDLE->RUN cycle leaves cnt at 0,
    // which is what makes the first s_tick land exactly dvsr_q cycles after en.
    assign running   = (state_q != IDLE) && en;
    assign cnt_lim   = stretch ? dvsr_q : (dvsr_q - DVSR_ONE);
    assign wrap      = running && (cnt_q == cnt_lim);
    assign cfg_ready = (state_q != PEND);
    assign xfer      = cfg_valid && cfg_ready;
    assign dvsr_ok   = (cfg_dvsr >= DVSR_MIN);

    always_comb begin
        state_d    = state_q;
        load_now   = 1'b0;
        load_pend  = 1'b0;
        apply_pend = 1'b0;
        case (state_q)
            IDLE: begin
                load_now = xfer && dvsr_ok;
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    // no boundary to wait for once stopped, so apply straight away
                    load_now = xfer && dvsr_ok;
                    state_d  = IDLE;
                end else if (xfer && dvsr_ok) begin
                    load_pend = 1'b1;
                    state_d   = PEND;
                end
            end
            PEND: begin
                if (!en) begin
                    apply_pend = 1'b1;
                    state_d    = IDLE;
                end else if (wrap) begin
                    apply_pend = 1'b1;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cfg_err_d  = xfer && !dvsr_ok;
        dvsr_d     = load_now ? cfg_dvsr : (apply_pend ? pend_q : dvsr_q);
        pend_d     = load_pend ? cfg_dvsr : pend_q;
        s_tick_d   = wrap;
        bit_tick_d = wrap && (ocnt_q == OCNT_MAX);
        cnt_d      = '0;
        ocnt_d     = '0;
        if (running) begin
            cnt_d  = wrap ? '0 : (cnt_q + DVSR_ONE);
            ocnt_d = ocnt_q;
            if (wrap) begin
                ocnt_d = (ocnt_q == OCNT_MAX) ? '0 : (ocnt_q + OCNT_ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ocnt_q     <= '0;
            dvsr_q     <= DVSR_RST;
            pend_q     <= DVSR_RST;
            s_tick_q   <= 1'b0;
            bit_tick_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ocnt_q     <= ocnt_d;
            dvsr_q     <= dvsr_d;
            pend_q     <= pend_d;
            s_tick_q   <= s_tick_d;
            bit_tick_q <= bit_tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

`ifdef BAUD_FRAC_EN
    // Fraction travels with its divisor through the same immediate/pending path.
    logic [3:0] frac_q, frac_d;
    logic [3:0] pend_frac_q, pend_frac_d;

    always_comb begin
        frac_d      = load_now ? cfg_frac : (apply_pend ? pend_frac_q : frac_q);
        pend_frac_d = load_pend ? cfg_frac : pend_frac_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frac_q      <= 4'd0;
            pend_frac_q <= 4'd0;
        end else begin
            frac_q      <= frac_d;
            pend_frac_q <= pend_frac_d;
        end
    end

    baud_frac_acc u_frac_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!running),
        .adv     (s_tick_d),
        .frac    (frac_q),
        .stretch (stretch)
    );
`else
    assign stretch = 1'b0;
`endif

    assign s_tick   = s_tick_q;
    assign bit_tick = bit_tick_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_baud_rate_ctrl.sv
// Purpose : directed self-checking bench for baud_rate_ctrl (default and BAUD_FRAC_EN builds).
// Latency : inputs driven and outputs sampled 1 ns after each rising clk edge.
// Backpressure: divisor writes are only offered when cfg_ready is expected high.
module tb_baud_rate_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        cfg_valid;
    logic [15:0] cfg_dvsr;
`ifdef BAUD_FRAC_EN
    logic [3:0]  cfg_frac;
`endif
    logic        cfg_ready;
    logic        cfg_err;
    logic        s_tick;
    logic        bit_tick;
    logic [15:0] dvsr_q;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int cyc0   = 0;
    int last_s = 0;
    int prev_s = 0;
    int last_b = 0;
    int prev_b = 0;
    int t1     = 0;

    baud_rate_ctrl #(
        .DVSR_W       (16),
        .DEFAULT_DVSR (326),
        .OVS          (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_dvsr  (cfg_dvsr),
`ifdef BAUD_FRAC_EN
        .cfg_frac  (cfg_frac),
`endif
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .s_tick    (s_tick),
        .bit_tick  (bit_tick),
        .dvsr_q    (dvsr_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // one clk; records the cycle numbers of the two most recent ticks of each kind
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (s_tick) begin
            prev_s = last_s;
            last_s = cyc;
        end
        if (bit_tick) begin
            prev_b = last_b;
            last_b = cyc;
        end
    endtask

    task automatic wait_s(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!s_tick && n < 7000);
        if (!s_tick) chk({tag, "_timeout"}, 32'(s_tick), 1);
    endtask

    task automatic wait_b(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bit_tick && n < 7000);
        if (!bit_tick) chk({tag, "_timeout"}, 32'(bit_tick), 1);
    endtask

    task automatic cfg_write(input logic [15:0] d);
        cfg_valid = 1'b1;
        cfg_dvsr  = d;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_dvsr  = 16'd0;
`ifdef BAUD_FRAC_EN
        cfg_frac  = 4'd0;
`endif
        step();
        step();
        chk("rst_ready", 32'(cfg_ready), 1);
        chk("rst_err",   32'(cfg_err),   0);
        chk("rst_stick", 32'(s_tick),    0);
        chk("rst_btick", 32'(bit_tick),  0);
        chk("rst_dvsr",  32'(dvsr_q),    326);
        reset_n = 1'b1;
        step();
        step();

        // default divisor
        en = 1'b1;
        step();
        cyc0 = cyc;
        wait_s("def_first");
        chk("def_first_stick", 32'(last_s - cyc0), 326);
        wait_s("def_second");
        chk("def_second_stick", 32'(last_s - cyc0), 652);
        wait_b("def_btick");
        chk("def_first_btick", 32'(last_b - cyc0), 5216);
        chk("def_btick_with_stick", 32'(s_tick), 1);

        // divisor 10 written in IDLE
        en = 1'b0;
        step();
        chk("idle_no_tick", 32'(s_tick), 0);
        chk("idle_ready", 32'(cfg_ready), 1);
        cfg_write(16'd10);
        chk("idle_dvsr_load", 32'(dvsr_q), 10);
        en = 1'b1;
        step();
        cyc0 = cyc;
        wait_s("d10_first");
        chk("d10_first_stick", 32'(last_s - cyc0), 10);
        wait_s("d10_period");
        chk("d10_period", 32'(last_s - prev_s), 10);
        wait_b("d10_btick");
        chk("d10_first_btick", 32'(last_b - cyc0), 160);
        wait_b("d10_bperiod");
        chk("d10_btick_period", 32'(last_b - prev_b), 160);

        // write 4 while running at cnt=3 (cnt is 0 on the tick sample)
        step();
        step();
        step();
        chk("run_ready", 32'(cfg_ready), 1);
        cfg_write(16'd4);
        chk("pend_ready", 32'(cfg_ready), 0);
        chk("pend_dvsr_old", 32'(dvsr_q), 10);
        wait_s("pend_wrap");
        chk("pend_old_period", 32'(last_s - prev_s), 10);
        chk("pend_applied", 32'(dvsr_q), 4);
        chk("pend_ready_back", 32'(cfg_ready), 1);
        wait_s("d4_period");
        chk("d4_period", 32'(last_s - prev_s), 4);

        // rejected divisors 1 then 0, back to back from cnt=0
        cfg_valid = 1'b1;
        cfg_dvsr  = 16'd1;
        step();
        cfg_dvsr  = 16'd0;
        chk("err1_pulse", 32'(cfg_err), 1);
        chk("err1_dvsr", 32'(dvsr_q), 4);
        chk("err1_ready", 32'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        chk("err0_pulse", 32'(cfg_err), 1);
        step();
        chk("err_clear", 32'(cfg_err), 0);
        wait_s("err_tick");
        chk("err_period", 32'(last_s - prev_s), 4);
        chk("err_dvsr", 32'(dvsr_q), 4);

        // drop en while a divisor is pending
        cfg_write(16'd7);
        chk("pend7_ready", 32'(cfg_ready), 0);
        en = 1'b0;
        step();
        chk("stop_no_tick", 32'(s_tick), 0);
        chk("stop_dvsr_applied", 32'(dvsr_q), 7);
        chk("stop_ready", 32'(cfg_ready), 1);
        step();
        chk("stop_still_quiet", 32'(s_tick), 0);
        en = 1'b1;
        step();
        cyc0 = cyc;
        wait_s("d7_first");
        chk("d7_first_stick", 32'(last_s - cyc0), 7);

`ifdef BAUD_FRAC_EN
        // dvsr 10 + 4/16: any 16 consecutive periods total 164 clks
        en = 1'b0;
        step();
        cfg_frac = 4'd4;
        cfg_write(16'd10);
        cfg_frac = 4'd0;
        en = 1'b1;
        step();
        wait_s("frac_first");
        t1 = last_s;
        for (int i = 0; i < 16; i++) wait_s("frac_run");
        chk("frac_16_periods", 32'(last_s - t1), 164);
        t1 = last_s;
        for (int i = 0; i < 16; i++) wait_s("frac_run2");
        chk("frac_16_periods_2", 32'(last_s - t1), 164);
`endif

        // reset mid-run with a divisor pending
        wait_s("pre_rst");
        cfg_write(16'd3);
        chk("rstpend_ready", 32'(cfg_ready), 0);
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(cfg_ready), 1);
        chk("mid_rst_err",   32'(cfg_err),   0);
        chk("mid_rst_stick", 32'(s_tick),    0);
        chk("mid_rst_btick", 32'(bit_tick),  0);
        chk("mid_rst_dvsr",  32'(dvsr_q),    326);
        en = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        en = 1'b1;
        step();
        cyc0 = cyc;
        wait_s("post_rst");
        chk("post_rst_first_stick", 32'(last_s - cyc0), 326);
        chk("post_rst_dvsr", 32'(dvsr_q), 326);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
